inst_fetch_responder: RTL and testbench
=======================================

INST_FETCH_RESPONDER -- requirements
Module: inst_fetch_responder

Interface
REQ-001 SHALL have parameter INDEX_W, default 12, virtual index width; bits [3:0] of the index are always zero.
REQ-002 SHALL have parameter TAG_W, default 20, physical tag width; TAG_W+INDEX_W = 32.
REQ-003 clk  in  1  clock; all state changes on posedge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 inst_req  in  1  fetch request from the PC stage.
REQ-006 inst_wr  in  1  always 0; ignored.
REQ-007 inst_size  in  2  always 2'b11 (16 bytes); ignored.
REQ-008 inst_index  in  INDEX_W  16-byte-aligned line index.
REQ-009 inst_wdata  in  32  ignored.
REQ-010 inst_index_ok  out  1  request accepted this cycle.
REQ-011 inst_tag  in  TAG_W  physical tag from the MMU; valid in LOOKUP.
REQ-012 inst_uncached  in  1  MMU attribute; valid in LOOKUP.
REQ-013 flush  in  1  cancels any outstanding fetch (exception or branch recovery).
REQ-014 inst_data_ok  out  1  inst_rdata valid; one-cycle pulse.
REQ-015 inst_rdata  out  128  four instructions; word0 is bits [31:0].
REQ-016 mem_arvalid/mem_arready  out/in  1/1  read-address handshake.
REQ-017 mem_araddr  out  32  {tag,index}; bits [3:0] = 0.
REQ-018 mem_arlen  out  8  constant 8'd3 (4 beats).
REQ-019 mem_rvalid/mem_rready  in/out  1/1  read-data handshake.
REQ-020 mem_rdata/mem_rlast  in  32/1  beat data; last-beat marker.

Function
REQ-021 SHALL implement states IDLE, LOOKUP, MISS_AR, MISS_R, RESP.
REQ-022 inst_index_ok = (state==IDLE) && !flush; accepting when it equals inst_req SHALL latch inst_index and enter LOOKUP.
REQ-023 In LOOKUP, hit = line_valid && line_tag=={inst_tag,latched_index[INDEX_W-1:4]} && !inst_uncached.
REQ-024 On a LOOKUP hit, inst_data_ok=1 and inst_rdata=line data in that same cycle; next state IDLE (latency: 1 cycle after acceptance).
REQ-025 On a LOOKUP miss, the address SHALL be latched and MISS_AR entered.
REQ-026 MISS_AR: mem_arvalid=1 with a stable address until mem_arready; then MISS_R.
REQ-027 MISS_R: mem_rready=1; each beat SHALL be stored at a 2-bit beat counter slot, then the counter increments; a beat with mem_rlast, or at counter==3, enters RESP.
REQ-028 RESP: inst_data_ok=1 with the assembled line; if not uncached, SHALL load line data/tag and set line_valid; next IDLE.
REQ-029 flush in LOOKUP SHALL return to IDLE without inst_data_ok.
REQ-030 flush in MISS_AR/MISS_R/RESP SHALL set a cancel flag; the AR handshake and all 4 beats SHALL still complete; inst_data_ok SHALL be suppressed; cacheable fill still occurs; cancel clears on entering IDLE.
REQ-031 flush with inst_req in IDLE: no acceptance (inst_index_ok=0).
REQ-032 inst_data_ok SHALL never assert outside LOOKUP-hit or RESP.

Reset
REQ-033 While rst=0: state IDLE, line_valid=0, beat counter 0, cancel 0; all outputs 0 except mem_arlen=3.
REQ-034 Reset mid-miss SHALL abandon the burst immediately; no data_ok after release.

Configuration
REQ-035 Macro FETCH_LINEBUF_EN defined: line buffer and hit path per REQ-023/024/028.
REQ-036 Macro undefined: no line-buffer registers; every LOOKUP goes to MISS_AR; RESP does no fill.

Verification
REQ-037 Index 0x120, tag 0x1FC00, cold: araddr=0x1FC00120, arlen=3; beats A,B,C,D -> data_ok once, rdata={D,C,B,A}.
REQ-038 Repeat same address (EN defined) -> data_ok one cycle after index_ok, no mem_arvalid, rdata={D,C,B,A}.
REQ-039 Same address with inst_uncached=1 -> full burst, line buffer unchanged.
REQ-040 flush during beat 2 -> remaining beats drained, rready=1 throughout, no data_ok; next index_ok only after IDLE.
REQ-041 mem_arready held 0 for 5 cycles -> arvalid and araddr stable all 5 cycles; flush then does not drop arvalid.
REQ-042 inst_req with flush=1 in IDLE -> index_ok=0, state stays IDLE.

Source files
------------

// File: rtl/inst_fetch_responder.sv
// -----------------------------------------------------------------------------
// inst_fetch_responder
//   Purpose     : instruction-fetch front end; serves one 16-byte line per
//                 request, from a single-line buffer on a hit or from a 4-beat
//                 memory read burst on a miss.
//   Latency     : line-buffer hit -> inst_data_ok 1 cycle after inst_index_ok;
//                 miss -> AR handshake + 4 beats + 1 response cycle.
//   Backpressure: accepts one request only in IDLE (inst_index_ok); the AR
//                 channel holds address stable until mem_arready; mem_rready
//                 is held high for the whole data phase.
//
// Configuration:
//   FETCH_LINEBUF_EN  defined   -> single-line buffer with hit path.
//                     undefined -> no line-buffer registers; every lookup
//                                  misses and the response does no fill.
//
// Ports:
//   clk, rst                 clock; synchronous active-low reset
//   inst_req/inst_index      request and 16-byte aligned line index
//   inst_index_ok            request accepted this cycle
//   inst_tag/inst_uncached   MMU result, valid in the lookup cycle
//   flush                    cancel any outstanding fetch
//   inst_data_ok/inst_rdata  one-cycle response pulse and 128-bit line
//   inst_wr/inst_size/inst_wdata   unused request fields
//   mem_ar* / mem_r*         read-address and read-data channels to memory
// -----------------------------------------------------------------------------
module inst_fetch_responder #(
  parameter int INDEX_W = 12,
  parameter int TAG_W   = 20
) (
  input  logic               clk,
  input  logic               rst,
  // fetch request
  input  logic               inst_req,
  input  logic               inst_wr,
  input  logic [1:0]         inst_size,
  input  logic [INDEX_W-1:0] inst_index,
  input  logic [31:0]        inst_wdata,
  output logic               inst_index_ok,
  // MMU result
  input  logic [TAG_W-1:0]   inst_tag,
  input  logic               inst_uncached,
  input  logic               flush,
  // response
  output logic               inst_data_ok,
  output logic [127:0]       inst_rdata,
  // memory read-address channel
  output logic               mem_arvalid,
  input  logic               mem_arready,
  output logic [31:0]        mem_araddr,
  output logic [7:0]         mem_arlen,
  // memory read-data channel
  input  logic               mem_rvalid,
  output logic               mem_rready,
  input  logic [31:0]        mem_rdata,
  input  logic               mem_rlast
);

  // Line tag covers everything above the 16-byte offset: {tag, index[hi:4]}.
  localparam int LINE_TAG_W = TAG_W + INDEX_W - 4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOOKUP  = 3'd1,
    S_MISS_AR = 3'd2,
    S_MISS_R  = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_next_state;

  logic [INDEX_W-1:0]   r_index;
  logic [31:0]          r_addr;
  logic                 r_uncached;
  logic                 r_cancel;
  logic [1:0]           r_beat_cnt;
  logic [3:0][31:0]     r_beats;

  logic                 w_hit;
  logic                 w_accept;
  logic                 w_beat_fire;
  logic                 w_beat_last;
  logic [LINE_TAG_W-1:0] w_lookup_tag;

`ifdef FETCH_LINEBUF_EN
  logic                  r_line_valid;
  logic [LINE_TAG_W-1:0] r_line_tag;
  logic [127:0]          r_line_data;
`endif

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  assign w_accept     = (r_state == S_IDLE) && inst_req && !flush;
  assign w_lookup_tag = {inst_tag, r_index[INDEX_W-1:4]};

`ifdef FETCH_LINEBUF_EN
  assign w_hit = r_line_valid && (r_line_tag == w_lookup_tag) && !inst_uncached;
`else
  assign w_hit = 1'b0;
`endif

  // mem_rready is high throughout MISS_R, so a valid beat always transfers.
  assign w_beat_fire = (r_state == S_MISS_R) && mem_rvalid;
  // A short burst (early rlast) still terminates the data phase.
  assign w_beat_last = w_beat_fire && (mem_rlast || (r_beat_cnt == 2'd3));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next_state = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (flush)      w_next_state = S_IDLE;
        else if (w_hit) w_next_state = S_IDLE;
        else            w_next_state = S_MISS_AR;
      end
      S_MISS_AR: begin
        // A flush here does not abort the request; the burst must complete.
        if (mem_arready) w_next_state = S_MISS_R;
      end
      S_MISS_R: begin
        if (w_beat_last) w_next_state = S_RESP;
      end
      S_RESP: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. Everything is forced to its idle value while reset is held,
  // so a burst abandoned by reset produces no stray handshakes.
  // ---------------------------------------------------------------------------
  always_comb begin
    inst_index_ok = 1'b0;
    inst_data_ok  = 1'b0;
    inst_rdata    = 128'd0;
    mem_arvalid   = 1'b0;
    mem_araddr    = 32'd0;
    mem_arlen     = 8'd3;
    mem_rready    = 1'b0;
    if (rst) begin
      mem_araddr = r_addr;
      case (r_state)
        S_IDLE: begin
          inst_index_ok = !flush;
        end
        S_LOOKUP: begin
`ifdef FETCH_LINEBUF_EN
          if (w_hit && !flush) begin
            inst_data_ok = 1'b1;
            inst_rdata   = r_line_data;
          end
`endif
        end
        S_MISS_AR: begin
          mem_arvalid = 1'b1;
        end
        S_MISS_R: begin
          mem_rready = 1'b1;
        end
        S_RESP: begin
          // A flush arriving in this very cycle also cancels the response.
          if (!r_cancel && !flush) begin
            inst_data_ok = 1'b1;
            inst_rdata   = r_beats;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Request / miss datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_index    <= '0;
      r_addr     <= 32'd0;
      r_uncached <= 1'b0;
      r_cancel   <= 1'b0;
      r_beat_cnt <= 2'd0;
      r_beats    <= '0;
    end else begin
      if (w_accept) begin
        r_index <= inst_index;
      end

      // The MMU result is only valid during LOOKUP, so capture both the
      // address and the cacheability for use in the later miss states.
      if ((r_state == S_LOOKUP) && (w_next_state == S_MISS_AR)) begin
        r_addr     <= {inst_tag, r_index[INDEX_W-1:4], 4'b0000};
        r_uncached <= inst_uncached;
      end

      if (w_next_state == S_IDLE) begin
        r_cancel <= 1'b0;
      end else if (flush && ((r_state == S_MISS_AR) || (r_state == S_MISS_R) ||
                             (r_state == S_RESP))) begin
        r_cancel <= 1'b1;
      end

      if (w_beat_fire) begin
        r_beats[r_beat_cnt] <= mem_rdata;
        r_beat_cnt          <= r_beat_cnt + 2'd1;
      end
      // Early rlast can leave the counter mid-line; restart every burst at 0.
      if (r_state == S_RESP) begin
        r_beat_cnt <= 2'd0;
      end
    end
  end

`ifdef FETCH_LINEBUF_EN
  // ---------------------------------------------------------------------------
  // Single-line buffer. Filled by every cacheable miss, cancelled or not, so
  // the line fetched for a mispredicted path is still reusable.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_line_valid <= 1'b0;
      r_line_tag   <= '0;
      r_line_data  <= 128'd0;
    end else if ((r_state == S_RESP) && !r_uncached) begin
      r_line_valid <= 1'b1;
      r_line_tag   <= r_addr[31:4];
      r_line_data  <= r_beats;
    end
  end
`endif

  // Request fields that a fetch-only port never uses.
  logic w_unused;
  assign w_unused = ^{inst_wr, inst_size, inst_wdata, inst_index[3:0],
                      r_index[3:0], r_uncached};

endmodule

// File: tb/tb_inst_fetch_responder.sv
module tb_inst_fetch_responder;

  localparam int INDEX_W = 12;
  localparam int TAG_W   = 20;

  logic               clk = 1'b0;
  logic               rst;
  logic               inst_req;
  logic               inst_wr;
  logic [1:0]         inst_size;
  logic [INDEX_W-1:0] inst_index;
  logic [31:0]        inst_wdata;
  logic               inst_index_ok;
  logic [TAG_W-1:0]   inst_tag;
  logic               inst_uncached;
  logic               flush;
  logic               inst_data_ok;
  logic [127:0]       inst_rdata;
  logic               mem_arvalid;
  logic               mem_arready;
  logic [31:0]        mem_araddr;
  logic [7:0]         mem_arlen;
  logic               mem_rvalid;
  logic               mem_rready;
  logic [31:0]        mem_rdata;
  logic               mem_rlast;

  always #5 clk = ~clk;

  inst_fetch_responder #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .inst_req      (inst_req),
    .inst_wr       (inst_wr),
    .inst_size     (inst_size),
    .inst_index    (inst_index),
    .inst_wdata    (inst_wdata),
    .inst_index_ok (inst_index_ok),
    .inst_tag      (inst_tag),
    .inst_uncached (inst_uncached),
    .flush         (flush),
    .inst_data_ok  (inst_data_ok),
    .inst_rdata    (inst_rdata),
    .mem_arvalid   (mem_arvalid),
    .mem_arready   (mem_arready),
    .mem_araddr    (mem_araddr),
    .mem_arlen     (mem_arlen),
    .mem_rvalid    (mem_rvalid),
    .mem_rready    (mem_rready),
    .mem_rdata     (mem_rdata),
    .mem_rlast     (mem_rlast)
  );

  int total = 0;
  int bad   = 0;

  // Scoreboard of responses the reference model says must appear.
  logic [127:0] exp_q[$];
  logic [127:0] mon_exp;

  // Reference model: one remembered line (address + data) when the buffer
  // is built in; otherwise nothing is ever a hit.
  bit           m_vld  = 1'b0;
  logic [31:0]  m_addr = 32'd0;
  logic [127:0] m_data = 128'd0;

  function automatic bit model_hit(input logic [31:0] addr, input bit unc);
`ifdef FETCH_LINEBUF_EN
    return m_vld && (m_addr == addr) && !unc;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every data_ok pulse must match the oldest expected response.
  always @(negedge clk) begin
    #2;
    if (inst_data_ok === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_data_ok: got rdata=%h want no response (t=%0t)", inst_rdata, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        if (inst_rdata !== mon_exp) begin
          bad++;
          $display("FAIL rdata: got %h want %h (t=%0t)", inst_rdata, mon_exp, $time);
        end
      end
    end
  end

  task automatic mem_idle();
    mem_arready = 1'b0;
    mem_rvalid  = 1'b0;
    mem_rlast   = 1'b0;
    mem_rdata   = 32'd0;
  endtask

  // One fetch transaction.
  // flush_at: -1 none, 0 in LOOKUP, 1 first AR cycle, 2..5 while presenting beat 0..3
  task automatic fetch(input logic [INDEX_W-1:0] idx, input logic [TAG_W-1:0] tag,
                       input bit unc, input int flush_at, input int ar_delay, input bit gaps);
    logic [31:0]  addr;
    logic [127:0] line;
    bit           hit;
    bit           cancel;
    int           beat;
    int           guard;
    addr   = {tag, idx};
    line   = 128'd0;
    cancel = 1'b0;

    @(negedge clk);
    inst_req = 1'b1; inst_index = idx; flush = 1'b0;
    #1;
    check("index_ok_idle", inst_index_ok, 1'b1);

    @(negedge clk);
    inst_req = 1'b0; inst_index = INDEX_W'($urandom);
    inst_tag = tag; inst_uncached = unc; flush = (flush_at == 0);
    hit = model_hit(addr, unc);
    if (hit && flush_at != 0) exp_q.push_back(m_data);
    #1;
    check("lookup_data_ok", inst_data_ok, hit && (flush_at != 0));
    check("lookup_no_arvalid", mem_arvalid, 1'b0);
    check("lookup_index_ok", inst_index_ok, 1'b0);

    if (flush_at == 0 || hit) begin
      @(negedge clk);
      flush = 1'b0; inst_uncached = 1'b0; inst_tag = TAG_W'($urandom);
      #1;
      check("after_lookup_idle", inst_index_ok, 1'b1);
      check("after_lookup_no_arvalid", mem_arvalid, 1'b0);
      return;
    end

    for (int c = 0; c <= ar_delay; c++) begin
      @(negedge clk);
      inst_tag = TAG_W'($urandom); inst_uncached = 1'($urandom);
      flush = (flush_at == 1) && (c == 0);
      if (flush) cancel = 1'b1;
      mem_arready = (c == ar_delay);
      #1;
      check("arvalid", mem_arvalid, 1'b1);
      check("araddr", mem_araddr, addr);
      check("arlen", mem_arlen, 8'd3);
      check("ar_no_rready", mem_rready, 1'b0);
    end

    beat  = 0;
    guard = 0;
    while (beat < 4 && guard < 64) begin
      guard++;
      @(negedge clk);
      mem_arready = 1'b0; flush = 1'b0;
      mem_rvalid  = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      mem_rdata   = $urandom;
      mem_rlast   = mem_rvalid && (beat == 3);
      if (mem_rvalid && flush_at == beat + 2) begin
        flush  = 1'b1;
        cancel = 1'b1;
      end
      #1;
      check("rready", mem_rready, 1'b1);
      check("burst_no_arvalid", mem_arvalid, 1'b0);
      if (mem_rvalid) begin
        line[beat*32 +: 32] = mem_rdata;
        beat++;
      end
    end

    @(negedge clk);
    mem_idle(); flush = 1'b0;
    if (!cancel) exp_q.push_back(line);
    #1;
    check("resp_data_ok", inst_data_ok, !cancel);
    check("resp_index_ok", inst_index_ok, 1'b0);
    check("resp_no_rready", mem_rready, 1'b0);
    if (!unc) begin
      m_vld  = 1'b1;
      m_addr = addr;
      m_data = line;
    end
  endtask

  task automatic flush_req_idle(input logic [INDEX_W-1:0] idx);
    @(negedge clk);
    inst_req = 1'b1; inst_index = idx; flush = 1'b1;
    #1;
    check("flush_req_index_ok", inst_index_ok, 1'b0);
    @(negedge clk);
    inst_req = 1'b0; flush = 1'b0;
    #1;
    check("flush_req_still_idle", inst_index_ok, 1'b1);
    check("flush_req_no_arvalid", mem_arvalid, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_index_ok"}, inst_index_ok, 1'b0);
    check({tag, "_data_ok"}, inst_data_ok, 1'b0);
    check({tag, "_rdata"}, inst_rdata, 128'd0);
    check({tag, "_arvalid"}, mem_arvalid, 1'b0);
    check({tag, "_araddr"}, mem_araddr, 32'd0);
    check({tag, "_arlen"}, mem_arlen, 8'd3);
    check({tag, "_rready"}, mem_rready, 1'b0);
  endtask

  task automatic reset_mid_miss(input logic [INDEX_W-1:0] idx, input logic [TAG_W-1:0] tag);
    @(negedge clk);
    inst_req = 1'b1; inst_index = idx;
    #1;
    check("rmm_index_ok", inst_index_ok, 1'b1);
    @(negedge clk);
    inst_req = 1'b0; inst_tag = tag; inst_uncached = 1'b1;
    @(negedge clk);
    inst_uncached = 1'b0; mem_arready = 1'b1;
    #1;
    check("rmm_arvalid", mem_arvalid, 1'b1);
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      mem_arready = 1'b0; mem_rvalid = 1'b1; mem_rdata = $urandom; mem_rlast = 1'b0;
      #1;
      check("rmm_rready", mem_rready, 1'b1);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = $urandom;
      #1;
      check_reset_outputs("rmm_reset");
    end
    m_vld = 1'b0;
    @(negedge clk);
    rst = 1'b1; mem_idle();
    for (int c = 0; c < 3; c++) begin
      #1;
      check("rmm_post_idle", inst_index_ok, 1'b1);
      check("rmm_post_data_ok", inst_data_ok, 1'b0);
      check("rmm_post_rready", mem_rready, 1'b0);
      @(negedge clk);
    end
  endtask

  function automatic logic [INDEX_W-1:0] pick_idx();
    case ($urandom_range(0, 2))
      0:       return 12'h120;
      1:       return 12'h340;
      default: return 12'hFF0;
    endcase
  endfunction

  initial begin
    #100000;
    bad++;
    $display("FAIL watchdog: got no completion want finish within time limit");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    int fa;
    rst = 1'b0;
    inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'b11; inst_index = '0;
    inst_wdata = 32'd0; inst_tag = '0; inst_uncached = 1'b0; flush = 1'b0;
    mem_idle();

    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    // cold miss, then repeat (hit when buffer present)
    fetch(12'h120, 20'h1FC00, 1'b0, -1, 0, 1'b0);
    fetch(12'h120, 20'h1FC00, 1'b0, -1, 0, 1'b0);
    // uncached: full burst, buffer untouched; cached repeat sees old line
    fetch(12'h120, 20'h1FC00, 1'b1, -1, 1, 1'b0);
    fetch(12'h120, 20'h1FC00, 1'b0, -1, 0, 1'b0);
    // flush during beat 2 of a new line, then reuse of the cancelled fill
    fetch(12'h340, 20'h00001, 1'b0, 3, 0, 1'b0);
    fetch(12'h340, 20'h00001, 1'b0, -1, 0, 1'b0);
    // AR stalled five cycles with a flush on the first
    fetch(12'hFF0, 20'h1FC00, 1'b0, 1, 5, 1'b1);
    // flush in lookup: on a (possible) hit and on a miss
    fetch(12'hFF0, 20'h1FC00, 1'b0, 0, 0, 1'b0);
    fetch(12'h120, 20'h00002, 1'b0, 0, 0, 1'b0);
    // request together with flush in IDLE
    flush_req_idle(12'h120);
    // reset abandons a burst and clears the buffer
    reset_mid_miss(12'h340, 20'h00001);
    fetch(12'hFF0, 20'h1FC00, 1'b0, -1, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 5))
        0:       fa = 0;
        1:       fa = 1;
        2:       fa = $urandom_range(2, 5);
        default: fa = -1;
      endcase
      fetch(pick_idx(), ($urandom_range(0, 1) != 0) ? 20'h1FC00 : 20'h00001,
            ($urandom_range(0, 4) == 0), fa, $urandom_range(0, 3),
            1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) flush_req_idle(pick_idx());
    end

    repeat (4) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover_responses: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
